ah_pl2ddr_burst_scheduler: RTL and testbench

- Sequences AXI write bursts for the PL2DDR path.
- Watches the BRAM fill level from data control and picks the next DDR address and burst length.
- Drives the AXI master's init/done handshake and handles ring-buffer wrap between the low and high DDR bounds.
- Sits between the command FSM, which supplies configuration and start/abort, and the AXI master.

---
 rtl/ah_pl2ddr_burst_scheduler_if.sv | 37 +++
 rtl/ah_pl2ddr_burst_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ah_pl2ddr_burst_scheduler.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ah_pl2ddr_burst_scheduler_if.sv
// rtl/ah_pl2ddr_burst_scheduler_if.sv - control/status bundle between command FSM, AXI master and scheduler
interface ah_pl2ddr_burst_scheduler_if;
    logic        start;
    logic        abort;
    logic        flush;
    logic [31:0] cfg_addr_low;
    logic [31:0] cfg_addr_high;
    logic [31:0] cfg_total_words;
    logic [9:0]  words_available;
    logic        txn_done;
    logic        axi_error;
    logic        tx_init;
    logic [31:0] burst_addr;
    logic [8:0]  burst_len;
    logic        busy;
    logic        done;
    logic        error;
    logic        cfg_error;
    logic        wrapped;
    logic [31:0] words_sent;
    logic [31:0] bursts_sent;
    logic [2:0]  state;

    modport master (
        input  start, abort, flush, cfg_addr_low, cfg_addr_high, cfg_total_words,
               words_available, txn_done, axi_error,
        output tx_init, burst_addr, burst_len, busy, done, error, cfg_error,
               wrapped, words_sent, bursts_sent, state
    );

    modport slave (
        output start, abort, flush, cfg_addr_low, cfg_addr_high, cfg_total_words,
               words_available, txn_done, axi_error,
        input  tx_init, burst_addr, burst_len, busy, done, error, cfg_error,
               wrapped, words_sent, bursts_sent, state
    );
endinterface

// File: rtl/ah_pl2ddr_burst_scheduler.sv
// rtl/ah_pl2ddr_burst_scheduler.sv - PL2DDR AXI write burst scheduler with ring-buffer wrap
module ah_pl2ddr_burst_scheduler #(
    parameter int MAX_BURST = 256,
    parameter bit WRAP_EN   = 1'b1
) (
    input  logic                           m_axi_out_aclk,
    input  logic                           m_axi_out_aresetn,
    ah_pl2ddr_burst_scheduler_if.master    bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        ADVANCE   = 3'd4,
        DONE      = 3'd5,
        ERROR     = 3'd6
    } state_t;

    localparam logic [32:0] MAX33 = 33'(MAX_BURST);

    state_t      st, nxt;
    logic [31:0] cur_addr, remaining, low_q, high_q;
    logic        cont_q, abort_pend, cfg_error_q, wrapped_q;
    logic [31:0] burst_addr_q, words_sent_q, bursts_sent_q;
    logic [8:0]  burst_len_q;

    logic        launch, bad_cfg, load, do_adv, do_wrap;
    logic [8:0]  len_sel, cand;
    logic [12:0] to4k_bytes;
    logic [32:0] high_p1, tohigh_bytes, to4k, tohigh, cand33, adv_addr;
    logic [31:0] adv_rem;

    always_comb begin
        high_p1      = {1'b0, high_q} + 33'd1;
        to4k_bytes   = 13'h1000 - {1'b0, cur_addr[11:0]};
        to4k         = {22'd0, to4k_bytes[12:2]};
        tohigh_bytes = high_p1 - {1'b0, cur_addr};
        tohigh       = {2'b00, tohigh_bytes[32:2]};
        cand33       = MAX33;
        if (to4k < cand33)
            cand33 = to4k;
        if (tohigh < cand33)
            cand33 = tohigh;
        if (!cont_q && ({1'b0, remaining} < cand33))
            cand33 = {1'b0, remaining};
        cand     = cand33[8:0];
        adv_addr = {1'b0, cur_addr} + {22'd0, burst_len_q, 2'b00};
        adv_rem  = remaining - {23'd0, burst_len_q};
    end

    assign bad_cfg = (bus.cfg_addr_low[1:0] != 2'b00) || (bus.cfg_addr_high[1:0] != 2'b11) ||
                     (bus.cfg_addr_high < bus.cfg_addr_low);
    assign launch  = bus.start && (st == IDLE || st == DONE || st == ERROR);
    // A txn_done coinciding with axi_error still retires its burst into the counters.
    assign do_adv  = (st == ADVANCE) || (st == WAIT_DONE && bus.txn_done && bus.axi_error);

    always_comb begin
        nxt     = st;
        load    = 1'b0;
        len_sel = cand;
        do_wrap = 1'b0;
        case (st)
            IDLE, DONE, ERROR: begin
                if (bus.start)
                    nxt = bad_cfg ? ERROR : WAIT_DATA;
            end
            WAIT_DATA: begin
                if (bus.axi_error)
                    nxt = ERROR;
                else if (bus.abort)
                    nxt = IDLE;
                else if (bus.words_available >= {1'b0, cand}) begin
                    load = 1'b1;
                    nxt  = ISSUE;
                end else if (bus.flush && bus.words_available != 10'd0) begin
                    load    = 1'b1;
                    len_sel = bus.words_available[8:0];
                    nxt     = ISSUE;
                end
            end
            ISSUE:     nxt = bus.axi_error ? ERROR : WAIT_DONE;
            WAIT_DONE: begin
                if (bus.axi_error)
                    nxt = ERROR;
                else if (bus.txn_done)
                    nxt = ADVANCE;
            end
            ADVANCE: begin
                if (bus.axi_error)
                    nxt = ERROR;
                else if (abort_pend || bus.abort)
                    nxt = IDLE;
                else if (!cont_q && adv_rem == 32'd0)
                    nxt = DONE;
                else if (adv_addr == high_p1) begin
                    do_wrap = WRAP_EN;
                    nxt     = WRAP_EN ? WAIT_DATA : DONE;
                end else
                    nxt = WAIT_DATA;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_out_aclk or negedge m_axi_out_aresetn) begin
        if (!m_axi_out_aresetn) begin
            st            <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            low_q         <= '0;
            high_q        <= '0;
            cont_q        <= 1'b0;
            abort_pend    <= 1'b0;
            cfg_error_q   <= 1'b0;
            wrapped_q     <= 1'b0;
            burst_addr_q  <= '0;
            burst_len_q   <= '0;
            words_sent_q  <= '0;
            bursts_sent_q <= '0;
        end else begin
            st         <= nxt;
            wrapped_q  <= do_wrap;
            abort_pend <= (st == ISSUE || st == WAIT_DONE) && (bus.abort || abort_pend);
            if (launch) begin
                low_q         <= bus.cfg_addr_low;
                high_q        <= bus.cfg_addr_high;
                cont_q        <= (bus.cfg_total_words == 32'd0);
                cur_addr      <= bus.cfg_addr_low;
                remaining     <= bus.cfg_total_words;
                words_sent_q  <= '0;
                bursts_sent_q <= '0;
                cfg_error_q   <= bad_cfg;
            end else begin
                if (load) begin
                    burst_addr_q <= cur_addr;
                    burst_len_q  <= len_sel;
                end
                if (do_adv) begin
                    cur_addr      <= do_wrap ? low_q : adv_addr[31:0];
                    remaining     <= adv_rem;
                    words_sent_q  <= words_sent_q + {23'd0, burst_len_q};
                    bursts_sent_q <= bursts_sent_q + 32'd1;
                end
            end
        end
    end

    assign bus.tx_init     = (st == ISSUE);
    assign bus.busy        = (st == WAIT_DATA) || (st == ISSUE) || (st == WAIT_DONE) || (st == ADVANCE);
    assign bus.done        = (st == DONE);
    assign bus.error       = (st == ERROR);
    assign bus.cfg_error   = cfg_error_q;
    assign bus.wrapped     = wrapped_q;
    assign bus.burst_addr  = burst_addr_q;
    assign bus.burst_len   = burst_len_q;
    assign bus.words_sent  = words_sent_q;
    assign bus.bursts_sent = bursts_sent_q;
    assign bus.state       = st;
endmodule

// File: tb/tb_ah_pl2ddr_burst_scheduler.sv
// tb/tb_ah_pl2ddr_burst_scheduler.sv - directed self-checking bench for the burst scheduler
module tb_ah_pl2ddr_burst_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   n;

    always #5 clk = ~clk;

    ah_pl2ddr_burst_scheduler_if b ();
    ah_pl2ddr_burst_scheduler_if b1 ();

    ah_pl2ddr_burst_scheduler #(.MAX_BURST(256), .WRAP_EN(1'b1)) u_dut (
        .m_axi_out_aclk(clk), .m_axi_out_aresetn(rst_n), .bus(b.master));
    ah_pl2ddr_burst_scheduler #(.MAX_BURST(256), .WRAP_EN(1'b0)) u_nowrap (
        .m_axi_out_aclk(clk), .m_axi_out_aresetn(rst_n), .bus(b1.master));

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] tw);
        b.cfg_addr_low    = lo;
        b.cfg_addr_high   = hi;
        b.cfg_total_words = tw;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
    endtask

    // Waits (bounded) for tx_init, checks the burst, and leaves the DUT in WAIT_DONE.
    task automatic issue(input string tag, input logic [31:0] ea, input logic [8:0] el);
        int k;
        k = 0;
        while (!b.tx_init && k < 300) begin
            tick();
            k++;
        end
        chk_eq({tag, "_seen"}, 64'(b.tx_init), 64'd1);
        chk_eq({tag, "_addr"}, 64'(b.burst_addr), 64'(ea));
        chk_eq({tag, "_len"}, 64'(b.burst_len), 64'(el));
        tick();
        chk_eq({tag, "_pulse"}, 64'(b.tx_init), 64'd0);
    endtask

    task automatic finish_burst();
        b.txn_done = 1'b1;
        tick();
        b.txn_done = 1'b0;
        tick();
    endtask

    initial begin
        {b.start, b.abort, b.flush, b.txn_done, b.axi_error} = '0;
        {b1.start, b1.abort, b1.flush, b1.txn_done, b1.axi_error} = '0;
        b.cfg_addr_low = '0; b.cfg_addr_high = '0; b.cfg_total_words = '0; b.words_available = '0;
        b1.cfg_addr_low = '0; b1.cfg_addr_high = '0; b1.cfg_total_words = '0; b1.words_available = '0;
        repeat (3) tick();
        chk_eq("rst_flags", 64'({b.tx_init, b.busy, b.done, b.error, b.cfg_error, b.wrapped, b.state, b.burst_len}), 64'd0);
        chk_eq("rst_addr_words", {b.burst_addr, b.words_sent}, 64'd0);
        rst_n = 1'b1;
        tick();
        b.words_available = 10'd1023;

        // two full 256-beat bursts
        start_run(32'h0010_0000, 32'h0010_07FF, 32'd512);
        chk_eq("t1_busy", 64'(b.busy), 64'd1);
        issue("t1_b0", 32'h0010_0000, 9'd256);
        finish_burst();
        issue("t1_b1", 32'h0010_0400, 9'd256);
        finish_burst();
        chk_eq("t1_done", 64'(b.done), 64'd1);
        chk_eq("t1_busy_end", 64'(b.busy), 64'd0);
        chk_eq("t1_words", 64'(b.words_sent), 64'd512);
        chk_eq("t1_bursts", 64'(b.bursts_sent), 64'd2);

        // 4 KB boundary split
        start_run(32'h0010_0F00, 32'h0010_1FFF, 32'd128);
        chk_eq("t2_done_clr", 64'(b.done), 64'd0);
        issue("t2_b0", 32'h0010_0F00, 9'd64);
        finish_burst();
        issue("t2_b1", 32'h0010_1000, 9'd64);
        finish_burst();
        chk_eq("t2_done", 64'(b.done), 64'd1);
        chk_eq("t2_words", 64'(b.words_sent), 64'd128);

        // ring wrap in continuous mode
        start_run(32'h0010_0000, 32'h0010_03FF, 32'd0);
        issue("t3_b0", 32'h0010_0000, 9'd256);
        finish_burst();
        chk_eq("t3_wrapped", 64'(b.wrapped), 64'd1);
        issue("t3_b1", 32'h0010_0000, 9'd256);
        chk_eq("t3_wrapped_once", 64'(b.wrapped), 64'd0);

        // start ignored while busy, abort waits for the in-flight burst
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        chk_eq("t6_start_ignored", 64'(b.state), 64'd3);
        b.abort = 1'b1;
        tick();
        b.abort = 1'b0;
        n = 0;
        repeat (10) begin
            if (b.tx_init) n++;
            tick();
        end
        chk_eq("t6_abort_hold_state", 64'(b.state), 64'd3);
        chk_eq("t6_abort_no_init", 64'(n), 64'd0);
        finish_burst();
        chk_eq("t6_abort_idle", 64'(b.state), 64'd0);
        chk_eq("t6_abort_bursts", 64'(b.bursts_sent), 64'd2);
        chk_eq("t6_abort_words", 64'(b.words_sent), 64'd512);
        n = 0;
        repeat (20) begin
            if (b.tx_init) n++;
            tick();
        end
        chk_eq("t6_abort_quiet", 64'(n), 64'd0);

        // no-wrap instance finishes at the high bound
        b1.cfg_addr_low = 32'h0010_0000;
        b1.cfg_addr_high = 32'h0010_03FF;
        b1.cfg_total_words = 32'd0;
        b1.words_available = 10'd1023;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        n = 0;
        while (!b1.tx_init && n < 50) begin
            tick();
            n++;
        end
        chk_eq("t3n_init", 64'(b1.tx_init), 64'd1);
        chk_eq("t3n_len", 64'(b1.burst_len), 64'd256);
        tick();
        b1.txn_done = 1'b1;
        tick();
        b1.txn_done = 1'b0;
        tick();
        chk_eq("t3n_done", 64'(b1.done), 64'd1);
        chk_eq("t3n_nowrap", 64'(b1.wrapped), 64'd0);

        // partial burst only under flush
        b.words_available = 10'd10;
        start_run(32'h0010_0000, 32'h0010_FFFF, 32'd100);
        n = 0;
        repeat (200) begin
            if (b.tx_init) n++;
            tick();
        end
        chk_eq("t4_starved", 64'(n), 64'd0);
        chk_eq("t4_wait_state", 64'(b.state), 64'd1);
        b.flush = 1'b1;
        issue("t4_b0", 32'h0010_0000, 9'd10);
        b.flush = 1'b0;
        finish_burst();
        b.words_available = 10'd1023;
        issue("t4_b1", 32'h0010_0028, 9'd90);
        finish_burst();
        chk_eq("t4_done", 64'(b.done), 64'd1);
        chk_eq("t4_words", 64'(b.words_sent), 64'd100);

        // AXI error handling
        start_run(32'h0010_0000, 32'h0010_FFFF, 32'd0);
        issue("t5_b0", 32'h0010_0000, 9'd256);
        b.axi_error = 1'b1;
        tick();
        b.axi_error = 1'b0;
        chk_eq("t5_error", 64'(b.error), 64'd1);
        chk_eq("t5_busy", 64'(b.busy), 64'd0);
        n = 0;
        repeat (100) begin
            if (b.tx_init) n++;
            tick();
        end
        chk_eq("t5_quiet", 64'(n), 64'd0);
        chk_eq("t5_sticky", 64'(b.error), 64'd1);
        start_run(32'h0010_0000, 32'h0010_FFFF, 32'd0);
        chk_eq("t5_error_clr", 64'(b.error), 64'd0);
        issue("t5_b1", 32'h0010_0000, 9'd256);
        b.txn_done = 1'b1;
        b.axi_error = 1'b1;
        tick();
        b.txn_done = 1'b0;
        b.axi_error = 1'b0;
        chk_eq("t5_both_state", 64'(b.state), 64'd6);
        chk_eq("t5_both_bursts", 64'(b.bursts_sent), 64'd1);
        chk_eq("t5_both_words", 64'(b.words_sent), 64'd256);

        // bad configurations
        start_run(32'h0010_0000, 32'h000F_FFFF, 32'd100);
        chk_eq("t5_cfg_order", 64'({b.cfg_error, b.error}), 64'd3);
        start_run(32'h0010_0002, 32'h0010_07FF, 32'd100);
        chk_eq("t5_cfg_low", 64'(b.cfg_error), 64'd1);
        start_run(32'h0010_0000, 32'h0010_07FE, 32'd100);
        chk_eq("t5_cfg_high", 64'(b.cfg_error), 64'd1);
        b.words_available = 10'd0;
        start_run(32'h0010_0000, 32'h0010_07FF, 32'd0);
        chk_eq("t5_cfg_clr", 64'({b.cfg_error, b.busy}), 64'd1);
        b.abort = 1'b1;
        tick();
        b.abort = 1'b0;
        chk_eq("t6_abort_wait_data", 64'(b.state), 64'd0);

        // asynchronous reset in the middle of a burst
        b.words_available = 10'd1023;
        start_run(32'h0010_0000, 32'h0010_FFFF, 32'd0);
        issue("t6r_b0", 32'h0010_0000, 9'd256);
        finish_burst();
        issue("t6r_b1", 32'h0010_0400, 9'd256);
        chk_eq("t6r_words_pre", 64'(b.words_sent), 64'd256);
        #3;
        rst_n = 1'b0;
        #1;
        chk_eq("t6r_flags", 64'({b.tx_init, b.busy, b.done, b.error, b.cfg_error, b.wrapped, b.state, b.burst_len}), 64'd0);
        chk_eq("t6r_addr_words", {b.burst_addr, b.words_sent}, 64'd0);
        chk_eq("t6r_bursts", 64'(b.bursts_sent), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
